// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// The optional misaligned-fetch trap is enabled with FETCH_MISALIGN_TRAP_EN.
package fetch_pkg;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

    localparam logic [ADDR_W-1:0] RESET_PC = 64'h0000_0000_8000_0000;

    // Exception cause code reported for a misaligned instruction fetch.
    localparam logic [3:0] CAUSE_MISALIGNED_FETCH = 4'd0;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
        logic               fault;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries; flush wins over pop and may load one entry.
// The head reads as all-zero while the queue is empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          i_clk,
    input  logic          i_arstn,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  din,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output fetch_entry_t  head
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && !full;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            // A flush may carry one entry in (the fault marker), landing in slot 0.
            rd_ptr <= '0;
            wr_ptr <= push ? AW'(1) : '0;
            count  <= push ? CW'(1) : '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (flush && push) begin
            mem[0] <= din;
        end else if (!flush && do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited sequential fetch, response queue, redirect flush.
// Define FETCH_MISALIGN_TRAP_EN to turn misaligned redirects into a single faulting entry.
module fetch_unit #(
    parameter int                ADDR_W   = fetch_pkg::ADDR_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
    input  logic              i_clk,
    input  logic              i_arstn,
    output logic              o_req_valid,
    input  logic              i_req_ready,
    output logic [ADDR_W-1:0] o_req_addr,
    input  logic              i_rsp_valid,
    input  logic [31:0]       i_rsp_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [31:0]       o_instr,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_fault,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc
);

    import fetch_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // A valid source holds its payload until accepted; responses have no ready and are never stalled.

    logic              started;
    logic              halted;
    logic [ADDR_W-1:0] req_pc;
    logic [ADDR_W-1:0] rsp_pc;
    logic [ADDR_W-1:0] redirect_pc;
    logic [CW-1:0]     in_flight;
    logic [CW-1:0]     drop_cnt;
    logic [CW-1:0]     q_count;
    logic [CW-1:0]     live_cnt;
    logic [CW:0]       credit_used;
    logic              misalign;
    logic              issue;
    logic              rsp_keep;
    logic              push;
    logic              pop;
    logic              q_empty;
    logic              q_full;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redirect_pc = i_redirect_pc;
    assign misalign    = i_redirect && (i_redirect_pc[1:0] != 2'b00);
    assign o_fault     = head.fault;
`else
    logic unused_fault;
    assign redirect_pc  = i_redirect_pc & ~ADDR_W'(3);
    assign misalign     = 1'b0;
    assign o_fault      = 1'b0;
    assign unused_fault = head.fault;
`endif

    // Live fetches exclude stale ones still owed by memory; modular difference is exact.
    assign live_cnt    = in_flight - drop_cnt;
    assign credit_used = {1'b0, live_cnt} + {1'b0, q_count};

    assign o_req_valid = started && !halted && !i_redirect && (credit_used < (CW+1)'(DEPTH));
    assign o_req_addr  = req_pc;
    assign issue       = o_req_valid && i_req_ready;
    assign rsp_keep    = i_rsp_valid && (drop_cnt == '0);
    assign push        = i_redirect ? misalign : rsp_keep;
    assign pop         = !i_redirect && !q_empty && i_ready;

    assign o_valid = !q_empty;
    assign o_instr = head.instr;
    assign o_pc    = head.pc;

    always_comb begin
        push_entry = '{pc: rsp_pc, instr: i_rsp_data, fault: 1'b0};
        if (misalign) begin
            push_entry = '{pc: redirect_pc, instr: '0, fault: 1'b1};
        end
    end

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            started   <= 1'b0;
            halted    <= 1'b0;
            req_pc    <= RESET_PC;
            rsp_pc    <= RESET_PC;
            in_flight <= '0;
            drop_cnt  <= '0;
        end else begin
            started   <= 1'b1;
            in_flight <= in_flight + CW'(issue) - CW'(i_rsp_valid);
            if (i_redirect) begin
                // Everything still owed by memory, minus this cycle's arrival, is stale.
                req_pc   <= redirect_pc;
                rsp_pc   <= redirect_pc;
                drop_cnt <= in_flight - CW'(i_rsp_valid);
                halted   <= misalign;
            end else begin
                if (issue)    req_pc <= req_pc + ADDR_W'(PC_STEP);
                if (rsp_keep) rsp_pc <= rsp_pc + ADDR_W'(PC_STEP);
                if (i_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .i_clk   (i_clk),
        .i_arstn (i_arstn),
        .push    (push),
        .pop     (pop),
        .flush   (i_redirect),
        .din     (push_entry),
        .count   (q_count),
        .empty   (q_empty),
        .full    (q_full),
        .head    (head)
    );

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_arstn)
        !(push && !i_redirect && q_full));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model with variable latency and a scoreboard queue.
module tb_fetch_unit;

  localparam int AW    = 64;
  localparam int DEPTH = 4;
  localparam int EW    = AW + 33;
  localparam logic [AW-1:0] RST_PC = 64'h0000_0000_8000_0000;

  logic          clk = 1'b0;
  logic          arstn;
  logic          req_ready;
  logic          rsp_valid;
  logic [31:0]   rsp_data;
  logic          ready;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          o_req_valid;
  logic [AW-1:0] o_req_addr;
  logic          o_valid;
  logic [31:0]   o_instr;
  logic [AW-1:0] o_pc;
  logic          o_fault;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(AW), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .i_clk         (clk),
    .i_arstn       (arstn),
    .o_req_valid   (o_req_valid),
    .i_req_ready   (req_ready),
    .o_req_addr    (o_req_addr),
    .i_rsp_valid   (rsp_valid),
    .i_rsp_data    (rsp_data),
    .o_valid       (o_valid),
    .i_ready       (ready),
    .o_instr       (o_instr),
    .o_pc          (o_pc),
    .o_fault       (o_fault),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc)
  );

  typedef struct {
    logic [AW-1:0] addr;
    int            epoch;
    int            due;
  } mreq_t;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [EW-1:0] exp_q[$];
  mreq_t         pend[$];
  int            epoch;
  int            cyc;
  int            mem_lat;
  int            fire_cnt;
  int            first_valid_cyc;
  int            rel_cyc;
  logic [AW-1:0] m_req_pc;
  logic [AW-1:0] m_rsp_pc;
  bit            m_started;
  bit            m_halted;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h0000_0013;
  endfunction

  function automatic int count_fresh();
    int n = 0;
    foreach (pend[i]) if (pend[i].epoch == epoch) n++;
    return n;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: sample and model at negedge, then drive memory response after posedge.
  task automatic tick();
    int            fr;
    logic          exp_rv;
    logic [EW-1:0] e;
    logic [AW-1:0] eff;
    @(negedge clk);
    fr     = count_fresh();
    exp_rv = m_started && !m_halted && !redirect && (fr + exp_q.size() < DEPTH);
    check("req_valid", o_req_valid, exp_rv);
    if (o_req_valid) check("req_addr", o_req_addr, m_req_pc);
    check("valid", o_valid, exp_q.size() != 0);
    if (o_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (redirect) begin
      if (rsp_valid) void'(pend.pop_front());
      exp_q.delete();
      epoch++;
      fire_cnt = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
      eff      = redirect_pc;
      m_halted = (redirect_pc[1:0] != 2'b00);
      if (m_halted) exp_q.push_back({redirect_pc, 32'h0, 1'b1});
`else
      eff = redirect_pc & ~64'd3;
`endif
      m_req_pc = eff;
      m_rsp_pc = eff;
    end else begin
      if (o_valid && ready) begin
        if (exp_q.size() == 0) begin
          check("pop_unexpected", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("pop_pc", o_pc, e[EW-1:33]);
          check("pop_instr", o_instr, e[32:1]);
          check("pop_fault", o_fault, e[0]);
        end
      end
      if (rsp_valid) begin
        if (pend[0].epoch == epoch) begin
          exp_q.push_back({m_rsp_pc, mem_word(pend[0].addr), 1'b0});
          m_rsp_pc = m_rsp_pc + 64'd4;
        end
        void'(pend.pop_front());
      end
      if (o_req_valid && req_ready) begin
        pend.push_back('{addr: o_req_addr, epoch: epoch, due: cyc + mem_lat});
        m_req_pc = m_req_pc + 64'd4;
        fire_cnt++;
      end
    end
    m_started = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = mem_word(pend[0].addr);
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = $urandom;
    end
  endtask

  task automatic pulse_redirect(input logic [AW-1:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    tick();
    redirect    = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input logic [AW-1:0] exp_pc, input logic exp_fault);
    int n = 0;
    while (!o_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_seen"}, o_valid, 1'b1);
    if (o_valid) begin
      check({tag, "_pc"}, o_pc, exp_pc);
      check({tag, "_fault"}, o_fault, exp_fault);
    end
  endtask

  task automatic do_reset();
    #2;
    arstn = 1'b0;
    #1;
    check("rst_req_valid", o_req_valid, 1'b0);
    check("rst_valid", o_valid, 1'b0);
    check("rst_instr", o_instr, 32'h0);
    check("rst_pc", o_pc, 64'h0);
    check("rst_fault", o_fault, 1'b0);
    pend.delete();
    exp_q.delete();
    epoch++;
    rsp_valid = 1'b0;
    redirect  = 1'b0;
    m_req_pc  = RST_PC;
    m_rsp_pc  = RST_PC;
    m_started = 1'b0;
    m_halted  = 1'b0;
    fire_cnt  = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    arstn           = 1'b1;
    rel_cyc         = cyc;
    first_valid_cyc = -1;
  endtask

  initial begin
    int n;
    arstn = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 32'h0;
    ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    epoch = 0; cyc = 0; mem_lat = 1; fire_cnt = 0; first_valid_cyc = -1;
    m_req_pc = RST_PC; m_rsp_pc = RST_PC; m_started = 1'b0; m_halted = 1'b0;

    #2;
    check("init_req_valid", o_req_valid, 1'b0);
    check("init_valid", o_valid, 1'b0);
    check("init_instr", o_instr, 32'h0);
    check("init_pc", o_pc, 64'h0);
    check("init_fault", o_fault, 1'b0);
    @(posedge clk);
    #1;
    arstn     = 1'b1;
    rel_cyc   = cyc;
    req_ready = 1'b1;
    ready     = 1'b1;

    // Streaming from reset with single-cycle memory.
    repeat (20) tick();
    check("first_valid_latency", first_valid_cyc - rel_cyc, 3);

    // Decode stall: fetch must stop at exactly DEPTH live fetches.
    ready = 1'b0;
    pulse_redirect(64'h0000_0000_8000_0400);
    repeat (16) tick();
    check("stall_fires", fire_cnt, DEPTH);
    check("stall_req_valid", o_req_valid, 1'b0);
    check("stall_valid", o_valid, 1'b1);
    ready = 1'b1;
    repeat (12) tick();

    // Redirect with three fetches outstanding to a slow memory.
    mem_lat = 4;
    n = 0;
    while (count_fresh() != 3 && n < 30) begin
      tick();
      n++;
    end
    pulse_redirect(64'h0000_0000_8000_1000);
    wait_valid("redir3", 64'h0000_0000_8000_1000, 1'b0);
    mem_lat = 1;

    // Redirect landing in the same cycle as a response.
    repeat (6) tick();
    n = 0;
    while (!rsp_valid && n < 10) begin
      tick();
      n++;
    end
    pulse_redirect(64'h0000_0000_8000_2000);
    wait_valid("redir_coincide", 64'h0000_0000_8000_2000, 1'b0);
    repeat (6) tick();

    // Misaligned redirect target.
    pulse_redirect(64'h0000_0000_8000_3002);
`ifdef FETCH_MISALIGN_TRAP_EN
    wait_valid("misalign_trap", 64'h0000_0000_8000_3002, 1'b1);
    repeat (8) tick();
    check("trap_halted", o_req_valid, 1'b0);
`else
    wait_valid("misalign_mask", 64'h0000_0000_8000_3000, 1'b0);
    repeat (8) tick();
`endif
    pulse_redirect(64'h0000_0000_8000_4000);
    wait_valid("resume", 64'h0000_0000_8000_4000, 1'b0);

    // PC wrap across the top of the address space.
    pulse_redirect(64'hFFFF_FFFF_FFFF_FFF8);
    repeat (14) tick();

    // Random back-pressure, latency and redirects.
    for (int i = 0; i < 400; i++) begin
      ready     = ($urandom_range(0, 3) != 0);
      req_ready = ($urandom_range(0, 3) != 0);
      if (i % 50 == 0) mem_lat = $urandom_range(1, 3);
      if ($urandom_range(0, 24) == 0) begin
        redirect    = 1'b1;
        redirect_pc = {32'h0, 32'($urandom)};
        if ($urandom_range(0, 3) != 0) redirect_pc[1:0] = 2'b00;
      end
      tick();
      redirect = 1'b0;
    end
    ready = 1'b1;
    req_ready = 1'b1;
    mem_lat = 1;
    pulse_redirect(64'h0000_0000_8000_5000);
    repeat (10) tick();

    // Asynchronous reset mid-stream, then restart from RESET_PC.
    do_reset();
    repeat (12) tick();
    check("reset_latency", first_valid_cyc - rel_cyc, 3);
    repeat (6) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
